sram_bank_arbiter: RTL and testbench

SRAM_BANK_ARBITER -- requirements
Module: sram_bank_arbiter

---
 rtl/sram_bank_arbiter.sv | 147 ++++++++++++++
 tb/tb_sram_bank_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// sram_bank_arbiter: round-robin arbiter that lets two requesters share one
// 4-bank SRAM. It handles one transaction at a time: a write takes ACCESS then
// IDLE, and a read takes ACCESS, RDWAIT, then a one-cycle rvalid pulse.
module sram_bank_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH),
  localparam int BAW  = AW - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_valid,
  output logic               m0_ready,
  input  logic               m0_we,
  input  logic [AW-1:0]      m0_addr,
  input  logic [WIDTH-1:0]   m0_wdata,
  output logic               m0_rvalid,
  input  logic               m1_valid,
  output logic               m1_ready,
  input  logic               m1_we,
  input  logic [AW-1:0]      m1_addr,
  input  logic [WIDTH-1:0]   m1_wdata,
  output logic               m1_rvalid,
  output logic [WIDTH-1:0]   rdata,
  output logic [3:0]         mem_sel,
  output logic               mem_wren,
  output logic               mem_rden,
  output logic [BAW-1:0]     mem_addr,
  output logic [WIDTH-1:0]   mem_wr_data,
  input  logic [4*WIDTH-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             ptr;
  logic             grant0;
  logic             grant1;
  logic             lat_we;
  logic             lat_id;
  logic [AW-1:0]    lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [1:0]       lat_bank;
  logic [WIDTH-1:0] bank_rd [4];

  assign lat_bank = lat_addr[AW-1:AW-2];
  assign m0_ready = grant0;
  assign m1_ready = grant1;

  // Split the packed bank read bus into one word per bank.
  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_rd[b] = mem_rd_data[b*WIDTH +: WIDTH];
    end
  end

  // Round-robin grant: only offered in IDLE; the pointer breaks ties, a lone requester always wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE && !rst) begin
      if (m0_valid && (!m1_valid || !ptr)) begin
        grant0 = 1'b1;
      end else if (m1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic plus the bank strobes, which are only live for the single ACCESS cycle.
  always_comb begin
    next_state  = state;
    mem_sel     = 4'b0000;
    mem_wren    = 1'b0;
    mem_rden    = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_sel     = 4'b0001 << lat_bank;
        mem_wren    = lat_we;
        mem_rden    = !lat_we;
        mem_addr    = lat_addr[BAW-1:0];
        mem_wr_data = lat_wdata;
        next_state  = lat_we ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Capture the winning command and hand priority to the requester that lost this round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= 1'b0;
      lat_we    <= 1'b0;
      lat_id    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant0 || grant1) begin
      ptr       <= grant0;
      lat_id    <= grant1;
      lat_we    <= grant0 ? m0_we    : m1_we;
      lat_addr  <= grant0 ? m0_addr  : m1_addr;
      lat_wdata <= grant0 ? m0_wdata : m1_wdata;
    end
  end

  // Register read data out of the selected bank during RDWAIT and pulse rvalid to the issuer; rdata holds afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      rdata     <= '0;
    end else begin
      m0_rvalid <= (state == RDWAIT) && !lat_id;
      m1_rvalid <= (state == RDWAIT) && lat_id;
      if (state == RDWAIT) begin
        rdata <= bank_rd[lat_bank];
      end
    end
  end

endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb_sram_bank_arbiter: random two-requester traffic against a transaction
// timeline model and a shadow memory, plus resets dropped into RDWAIT.
module tb_sram_bank_arbiter;

  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int BAW   = 8;
  localparam int NCYC  = 3000;

  logic               clk = 1'b0;
  logic               rst;
  logic               m0_valid, m0_ready, m0_we, m0_rvalid;
  logic               m1_valid, m1_ready, m1_we, m1_rvalid;
  logic [AW-1:0]      m0_addr, m1_addr;
  logic [WIDTH-1:0]   m0_wdata, m1_wdata;
  logic [WIDTH-1:0]   rdata;
  logic [3:0]         mem_sel;
  logic               mem_wren, mem_rden;
  logic [BAW-1:0]     mem_addr;
  logic [WIDTH-1:0]   mem_wr_data;
  logic [4*WIDTH-1:0] mem_rd_data;

  sram_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid),
    .rdata(rdata), .mem_sel(mem_sel), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Emulated SRAM banks: read data appears the cycle after mem_rden; idle lanes carry noise.
  logic [WIDTH-1:0] sram [0:DEPTH-1];
  bit               written [0:DEPTH-1];
  logic [WIDTH-1:0] rd_bus [4];

  function automatic logic [WIDTH-1:0] init_word(input int i);
    return WIDTH'((i * 40503 + 12345) ^ 16'h5A5A);
  endfunction

  function automatic logic [WIDTH-1:0] read_word(input int i);
    return written[i] ? sram[i] : init_word(i);
  endfunction

  assign mem_rd_data = {rd_bus[3], rd_bus[2], rd_bus[1], rd_bus[0]};

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_rden && mem_sel[b]) rd_bus[b] <= read_word(b * 256 + int'(mem_addr));
      else rd_bus[b] <= WIDTH'($urandom);
      if (mem_wren && mem_sel[b]) begin
        sram[b * 256 + int'(mem_addr)]    <= mem_wr_data;
        written[b * 256 + int'(mem_addr)] <= 1'b1;
      end
    end
  end

  // Reference model: expected ACCESS and response events placed on a cycle timeline.
  typedef struct {
    bit               v;
    bit               we;
    bit               id;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } ev_t;

  ev_t              acc_s [0:NCYC+8];
  ev_t              rsp_s [0:NCYC+8];
  logic [WIDTH-1:0] shadow [0:DEPTH-1];
  logic [WIDTH-1:0] hold;
  int               cyc, free_at, last_rst, resets;
  bit               ptr, hs0, hs1;
  bit               exp_r0, exp_r1;
  int               checks = 0;
  int               fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic newCommand(output logic v, output logic we, output logic [AW-1:0] a,
                            output logic [WIDTH-1:0] d);
    v  = ($urandom_range(0, 9) < 6);
    we = $urandom_range(0, 1) == 1;
    a  = {2'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
    d  = WIDTH'($urandom);
  endtask

  // A requester keeps its command stable until accepted, then draws a new one (or goes quiet).
  task automatic applyStimulus();
    if (!m0_valid || hs0) newCommand(m0_valid, m0_we, m0_addr, m0_wdata);
    if (!m1_valid || hs1) newCommand(m1_valid, m1_we, m1_addr, m1_wdata);
  endtask

  task automatic checkCycle();
    ev_t a, r;
    a = acc_s[cyc];
    r = rsp_s[cyc];
    if (r.v) hold = r.data;
    checkOutput("m0_ready", 32'(m0_ready), 32'(exp_r0));
    checkOutput("m1_ready", 32'(m1_ready), 32'(exp_r1));
    checkOutput("mem_sel", 32'(mem_sel), a.v ? 32'(4'b0001 << a.addr[AW-1:AW-2]) : 32'd0);
    checkOutput("mem_wren", 32'(mem_wren), 32'(a.v && a.we));
    checkOutput("mem_rden", 32'(mem_rden), 32'(a.v && !a.we));
    checkOutput("mem_addr", 32'(mem_addr), a.v ? 32'(a.addr[BAW-1:0]) : 32'd0);
    checkOutput("mem_wr_data", 32'(mem_wr_data), a.v ? 32'(a.data) : 32'd0);
    checkOutput("m0_rvalid", 32'(m0_rvalid), 32'(r.v && !r.id));
    checkOutput("m1_rvalid", 32'(m1_rvalid), 32'(r.v && r.id));
    checkOutput("rdata", 32'(rdata), 32'(hold));
  endtask

  initial begin
    bit do_rst, win;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    for (int i = 0; i <= NCYC + 8; i++) begin
      acc_s[i] = '{v: 1'b0, we: 1'b0, id: 1'b0, addr: '0, data: '0};
      rsp_s[i] = '{v: 1'b0, we: 1'b0, id: 1'b0, addr: '0, data: '0};
    end
    rst = 1'b1;
    {m0_valid, m0_we, m1_valid, m1_we} = '0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    ptr = 1'b0; hs0 = 1'b0; hs1 = 1'b0; hold = '0;
    free_at = 0; last_rst = 0; resets = 0;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      do_rst = (cyc < 3) || (cyc > 50 && rsp_s[cyc+1].v && resets < 4 && cyc - last_rst > 200);
      if (do_rst && cyc >= 3) begin
        resets++;
        last_rst = cyc;
      end
      rst = do_rst;
      applyStimulus();
      #1;
      hs0 = 1'b0;
      hs1 = 1'b0;
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      if (rst) begin
        for (int i = cyc; i <= NCYC + 8; i++) begin
          acc_s[i].v = 1'b0;
          rsp_s[i].v = 1'b0;
        end
        ptr = 1'b0;
        hold = '0;
        free_at = cyc + 1;
      end else if (cyc >= free_at && (m0_valid || m1_valid)) begin
        win = (m0_valid && m1_valid) ? ptr : m1_valid;
        exp_r0 = !win;
        exp_r1 = win;
      end
      checkCycle();
      if (exp_r0 || exp_r1) begin
        ev_t e;
        e.v    = 1'b1;
        e.id   = exp_r1;
        e.we   = exp_r1 ? m1_we    : m0_we;
        e.addr = exp_r1 ? m1_addr  : m0_addr;
        e.data = exp_r1 ? m1_wdata : m0_wdata;
        acc_s[cyc+1] = e;
        if (e.we) begin
          shadow[e.addr] = e.data;
          free_at = cyc + 2;
        end else begin
          rsp_s[cyc+3]      = e;
          rsp_s[cyc+3].data = shadow[e.addr];
          free_at = cyc + 3;
        end
        ptr = !exp_r1;
        hs0 = exp_r0;
        hs1 = exp_r1;
      end
    end

    checkOutput("rdwait_resets_hit", 32'(resets > 0), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
